// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: one reservation-station pool with CDB wakeup, oldest-ready
// select and a single valid/ready issue register toward the functional unit.
module rs_issue_scheduler #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned FUNC_W = 4,
    parameter int unsigned REG_W  = 4
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [FUNC_W-1:0]            alloc_func,
    input  logic [TAG_W-1:0]             alloc_rob,
    input  logic [REG_W-1:0]             alloc_rd,
    input  logic                         alloc_s1_rdy,
    input  logic [DATA_W-1:0]            alloc_s1_val,
    input  logic                         alloc_s2_rdy,
    input  logic [DATA_W-1:0]            alloc_s2_val,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         issue_valid,
    input  logic                         fu_ready,
    output logic [FUNC_W-1:0]            issue_func,
    output logic [TAG_W-1:0]             issue_rob,
    output logic [REG_W-1:0]             issue_rd,
    output logic [DATA_W-1:0]            issue_s1,
    output logic [DATA_W-1:0]            issue_s2,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned AGE_W = $clog2(DEPTH);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic              valid;
        logic [FUNC_W-1:0] func;
        logic [TAG_W-1:0]  rob;
        logic [REG_W-1:0]  rd;
        logic              s1_rdy;
        logic [DATA_W-1:0] s1;
        logic              s2_rdy;
        logic [DATA_W-1:0] s2;
        logic [AGE_W-1:0]  age;
    } entry_t;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [TAG_W-1:0]  rob;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
    } issue_t;

    entry_t [DEPTH-1:0] ent_q, ent_d;
    issue_t             iss_q, iss_d;
    logic               iss_valid_q, iss_valid_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               alloc_ready_q, alloc_ready_d;

    logic               cand_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [AGE_W-1:0]   sel_age;
    issue_t             sel_pay;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_load;
    logic               alloc_fire;
    entry_t             new_ent;

    // Oldest-ready select and lowest free slot, from registered state only
    always_comb begin
        cand_found = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        sel_pay    = '0;
        free_idx   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy &&
                (!cand_found || (ent_q[i].age > sel_age))) begin
                cand_found   = 1'b1;
                sel_idx      = IDX_W'(i);
                sel_age      = ent_q[i].age;
                sel_pay.func = ent_q[i].func;
                sel_pay.rob  = ent_q[i].rob;
                sel_pay.rd   = ent_q[i].rd;
                sel_pay.s1   = ent_q[i].s1;
                sel_pay.s2   = ent_q[i].s2;
            end
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Incoming entry with same-cycle CDB bypass on not-ready operands
    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.func   = alloc_func;
        new_ent.rob    = alloc_rob;
        new_ent.rd     = alloc_rd;
        new_ent.s1_rdy = alloc_s1_rdy;
        new_ent.s1     = alloc_s1_val;
        new_ent.s2_rdy = alloc_s2_rdy;
        new_ent.s2     = alloc_s2_val;
        new_ent.age    = '0;
        if (!alloc_s1_rdy && cdb_valid && (alloc_s1_val[TAG_W-1:0] == cdb_tag)) begin
            new_ent.s1_rdy = 1'b1;
            new_ent.s1     = cdb_data;
        end
        if (!alloc_s2_rdy && cdb_valid && (alloc_s2_val[TAG_W-1:0] == cdb_tag)) begin
            new_ent.s2_rdy = 1'b1;
            new_ent.s2     = cdb_data;
        end
    end

    // Next state: alloc, wakeup and issue together; flush overrides all three
    always_comb begin
        ent_d         = ent_q;
        iss_d         = iss_q;
        iss_valid_d   = iss_valid_q;
        occ_d         = '0;
        alloc_ready_d = 1'b0;
        issue_load    = cand_found && (!iss_valid_q || fu_ready);
        alloc_fire    = alloc_valid && alloc_ready_q;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_q[i].valid) begin
                if (cdb_valid && !ent_q[i].s1_rdy && (ent_q[i].s1[TAG_W-1:0] == cdb_tag)) begin
                    ent_d[i].s1_rdy = 1'b1;
                    ent_d[i].s1     = cdb_data;
                end
                if (cdb_valid && !ent_q[i].s2_rdy && (ent_q[i].s2[TAG_W-1:0] == cdb_tag)) begin
                    ent_d[i].s2_rdy = 1'b1;
                    ent_d[i].s2     = cdb_data;
                end
                if (alloc_fire && (ent_q[i].age != AGE_W'(DEPTH - 1))) begin
                    ent_d[i].age = ent_q[i].age + AGE_W'(1);
                end
                if (issue_load && (sel_idx == IDX_W'(i))) begin
                    ent_d[i].valid = 1'b0;
                end
            end else if (alloc_fire && (free_idx == IDX_W'(i))) begin
                ent_d[i] = new_ent;
            end
        end

        if (issue_load) begin
            iss_d       = sel_pay;
            iss_valid_d = 1'b1;
        end else if (fu_ready) begin
            iss_valid_d = 1'b0;
        end

        if (flush) begin
            ent_d       = '0;
            iss_valid_d = 1'b0;
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_d[i].valid) begin
                occ_d = occ_d + OCC_W'(1);
            end else begin
                alloc_ready_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk1) begin
        if (rst) begin
            ent_q         <= '0;
            iss_q         <= '0;
            iss_valid_q   <= 1'b0;
            occ_q         <= '0;
            alloc_ready_q <= 1'b1;
        end else begin
            ent_q         <= ent_d;
            iss_q         <= iss_d;
            iss_valid_q   <= iss_valid_d;
            occ_q         <= occ_d;
            alloc_ready_q <= alloc_ready_d;
        end
    end

    assign alloc_ready = alloc_ready_q;
    assign occupancy   = occ_q;
    assign issue_valid = iss_valid_q;
    assign issue_func  = iss_q.func;
    assign issue_rob   = iss_q.rob;
    assign issue_rd    = iss_q.rd;
    assign issue_s1    = iss_q.s1;
    assign issue_s2    = iss_q.s2;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler (DEPTH=3, DATA_W=16, TAG_W=3).
module tb_rs_issue_scheduler;

    logic        clk1;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_func;
    logic [2:0]  alloc_rob;
    logic [3:0]  alloc_rd;
    logic        alloc_s1_rdy;
    logic [15:0] alloc_s1_val;
    logic        alloc_s2_rdy;
    logic [15:0] alloc_s2_val;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        issue_valid;
    logic        fu_ready;
    logic [3:0]  issue_func;
    logic [2:0]  issue_rob;
    logic [3:0]  issue_rd;
    logic [15:0] issue_s1;
    logic [15:0] issue_s2;
    logic [1:0]  occupancy;

    int n_cmp;
    int n_err;

    rs_issue_scheduler dut (
        .clk1         (clk1),
        .rst          (rst),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_func   (alloc_func),
        .alloc_rob    (alloc_rob),
        .alloc_rd     (alloc_rd),
        .alloc_s1_rdy (alloc_s1_rdy),
        .alloc_s1_val (alloc_s1_val),
        .alloc_s2_rdy (alloc_s2_rdy),
        .alloc_s2_val (alloc_s2_val),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .issue_valid  (issue_valid),
        .fu_ready     (fu_ready),
        .issue_func   (issue_func),
        .issue_rob    (issue_rob),
        .issue_rd     (issue_rd),
        .issue_s1     (issue_s1),
        .issue_s2     (issue_s2),
        .occupancy    (occupancy)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic set_alloc(input logic [3:0] func, input logic [2:0] rob, input logic [3:0] rd,
                             input logic s1r, input logic [15:0] s1v,
                             input logic s2r, input logic [15:0] s2v);
        alloc_valid  = 1'b1;
        alloc_func   = func;
        alloc_rob    = rob;
        alloc_rd     = rd;
        alloc_s1_rdy = s1r;
        alloc_s1_val = s1v;
        alloc_s2_rdy = s2r;
        alloc_s2_val = s2v;
    endtask

    task automatic set_cdb(input logic v, input logic [2:0] tag, input logic [15:0] data);
        cdb_valid = v;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    // Build two waiting entries behind a parked instruction in the issue register
    task automatic load_two_waiting();
        fu_ready = 1'b0;
        set_alloc(4'h1, 3'd5, 4'd1, 1'b1, 16'h0001, 1'b1, 16'h0002);
        tick();
        set_alloc(4'h2, 3'd6, 4'd2, 1'b0, 16'h0006, 1'b1, 16'h0003);
        tick();
        set_alloc(4'h3, 3'd0, 4'd3, 1'b1, 16'h0004, 1'b0, 16'h0006);
        tick();
        alloc_valid = 1'b0;
        check_eq("pre_sq_occ", 32'(occupancy), 32'd2);
        check_eq("pre_sq_ivalid", 32'(issue_valid), 32'd1);
        check_eq("pre_sq_irob", 32'(issue_rob), 32'd5);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk1 = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        alloc_valid = 1'b0;
        alloc_func = '0;
        alloc_rob = '0;
        alloc_rd = '0;
        alloc_s1_rdy = 1'b0;
        alloc_s1_val = '0;
        alloc_s2_rdy = 1'b0;
        alloc_s2_val = '0;
        fu_ready = 1'b0;
        set_cdb(1'b0, 3'd0, 16'h0000);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check_eq("rst_issue_valid", 32'(issue_valid), 32'd0);
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        check_eq("rst_issue_rob", 32'(issue_rob), 32'd0);
        check_eq("rst_issue_s1", 32'(issue_s1), 32'd0);

        // 1: ready ADD issues two edges after the offer
        fu_ready = 1'b1;
        set_alloc(4'h0, 3'd2, 4'd3, 1'b1, 16'd5, 1'b1, 16'd7);
        tick();
        alloc_valid = 1'b0;
        check_eq("t1_occ1", 32'(occupancy), 32'd1);
        check_eq("t1_ivalid0", 32'(issue_valid), 32'd0);
        tick();
        check_eq("t1_ivalid1", 32'(issue_valid), 32'd1);
        check_eq("t1_s1", 32'(issue_s1), 32'd5);
        check_eq("t1_s2", 32'(issue_s2), 32'd7);
        check_eq("t1_rob", 32'(issue_rob), 32'd2);
        check_eq("t1_rd", 32'(issue_rd), 32'd3);
        check_eq("t1_func", 32'(issue_func), 32'd0);
        check_eq("t1_occ0", 32'(occupancy), 32'd0);
        tick();
        check_eq("t1_drain", 32'(issue_valid), 32'd0);

        // 2a: wakeup one cycle after allocation
        set_alloc(4'h9, 3'd1, 4'd5, 1'b0, 16'h0004, 1'b1, 16'h0003);
        tick();
        alloc_valid = 1'b0;
        check_eq("t2a_occ", 32'(occupancy), 32'd1);
        check_eq("t2a_ivalid0", 32'(issue_valid), 32'd0);
        set_cdb(1'b1, 3'd4, 16'h00AA);
        tick();
        set_cdb(1'b0, 3'd0, 16'h0000);
        check_eq("t2a_wait", 32'(issue_valid), 32'd0);
        tick();
        check_eq("t2a_ivalid1", 32'(issue_valid), 32'd1);
        check_eq("t2a_s1", 32'(issue_s1), 32'h00AA);
        check_eq("t2a_s2", 32'(issue_s2), 32'h0003);
        check_eq("t2a_rob", 32'(issue_rob), 32'd1);
        check_eq("t2a_func", 32'(issue_func), 32'h9);
        tick();
        check_eq("t2a_drain", 32'(issue_valid), 32'd0);

        // 2b: same-cycle bypass into the allocating entry
        set_alloc(4'h9, 3'd1, 4'd5, 1'b0, 16'h0004, 1'b1, 16'h0003);
        set_cdb(1'b1, 3'd4, 16'h00AA);
        tick();
        alloc_valid = 1'b0;
        set_cdb(1'b0, 3'd0, 16'h0000);
        check_eq("t2b_occ", 32'(occupancy), 32'd1);
        tick();
        check_eq("t2b_ivalid", 32'(issue_valid), 32'd1);
        check_eq("t2b_s1", 32'(issue_s1), 32'h00AA);
        tick();
        check_eq("t2b_drain", 32'(issue_valid), 32'd0);

        // 3/4/5: park rob 7, fill pool with rob 0 (waiting), 1, 2
        fu_ready = 1'b0;
        set_alloc(4'h2, 3'd7, 4'd7, 1'b1, 16'h0001, 1'b1, 16'h0002);
        tick();
        set_alloc(4'h3, 3'd0, 4'd8, 1'b0, 16'h0005, 1'b1, 16'h0010);
        tick();
        check_eq("t3_park", 32'(issue_rob), 32'd7);
        set_alloc(4'h4, 3'd1, 4'd9, 1'b1, 16'h0011, 1'b1, 16'h0012);
        tick();
        set_alloc(4'h5, 3'd2, 4'd10, 1'b1, 16'h0021, 1'b1, 16'h0022);
        tick();
        check_eq("t3_occ3", 32'(occupancy), 32'd3);
        check_eq("t3_full", 32'(alloc_ready), 32'd0);
        check_eq("t3_ivalid", 32'(issue_valid), 32'd1);

        // Full pool: rob 3 offered and held, FU stalled for 4 cycles
        set_alloc(4'h6, 3'd3, 4'd11, 1'b1, 16'h0033, 1'b1, 16'h0044);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t4_hold_rob", 32'(issue_rob), 32'd7);
            check_eq("t4_hold_s1", 32'(issue_s1), 32'h0001);
            check_eq("t4_hold_occ", 32'(occupancy), 32'd3);
            check_eq("t5_hold_ready", 32'(alloc_ready), 32'd0);
        end
        fu_ready = 1'b1;
        tick();
        check_eq("t4_next_rob", 32'(issue_rob), 32'd1);
        check_eq("t4_next_s1", 32'(issue_s1), 32'h0011);
        check_eq("t5_no_early", 32'(occupancy), 32'd2);
        check_eq("t5_ready_up", 32'(alloc_ready), 32'd1);
        tick();
        alloc_valid = 1'b0;
        check_eq("t3_rob2", 32'(issue_rob), 32'd2);
        check_eq("t5_accept_occ", 32'(occupancy), 32'd2);
        set_cdb(1'b1, 3'd5, 16'h0055);
        tick();
        set_cdb(1'b0, 3'd0, 16'h0000);
        check_eq("t5_rob3", 32'(issue_rob), 32'd3);
        check_eq("t5_rob3_s2", 32'(issue_s2), 32'h0044);
        check_eq("t3_occ1", 32'(occupancy), 32'd1);
        tick();
        check_eq("t3_rob0", 32'(issue_rob), 32'd0);
        check_eq("t3_rob0_s1", 32'(issue_s1), 32'h0055);
        check_eq("t3_occ0", 32'(occupancy), 32'd0);
        tick();
        check_eq("t3_drain", 32'(issue_valid), 32'd0);
        tick();
        check_eq("empty_fu_ready", 32'(issue_valid), 32'd0);
        check_eq("empty_occ", 32'(occupancy), 32'd0);

        // 6a: flush with alloc and cdb in the same cycle
        load_two_waiting();
        flush = 1'b1;
        set_alloc(4'h7, 3'd4, 4'd12, 1'b1, 16'h0077, 1'b1, 16'h0078);
        set_cdb(1'b1, 3'd6, 16'h0066);
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        set_cdb(1'b0, 3'd0, 16'h0000);
        check_eq("t6f_occ", 32'(occupancy), 32'd0);
        check_eq("t6f_ivalid", 32'(issue_valid), 32'd0);
        check_eq("t6f_ready", 32'(alloc_ready), 32'd1);
        fu_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t6f_no_issue", 32'(issue_valid), 32'd0);
        end

        // 6b: same scenario squashed by reset
        load_two_waiting();
        rst = 1'b1;
        set_alloc(4'h7, 3'd4, 4'd12, 1'b1, 16'h0077, 1'b1, 16'h0078);
        set_cdb(1'b1, 3'd6, 16'h0066);
        tick();
        rst = 1'b0;
        alloc_valid = 1'b0;
        set_cdb(1'b0, 3'd0, 16'h0000);
        check_eq("t6r_occ", 32'(occupancy), 32'd0);
        check_eq("t6r_ivalid", 32'(issue_valid), 32'd0);
        check_eq("t6r_ready", 32'(alloc_ready), 32'd1);
        check_eq("t6r_irob", 32'(issue_rob), 32'd0);
        fu_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t6r_no_issue", 32'(issue_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
